// File: rtl/id_issue_buffer_pkg.sv
// Shared types and constants for the decode-to-EXE issue buffer.
// Holds the serialisation state encoding and the micro-op field layout.
package id_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_BUBBLE,
    S_NOTIFY
  } ser_state_e;

  localparam logic [127:0] NOP_UOP = '0;

  // Field layout of the default 128-bit micro-op bundle.
  localparam int INSTR_LSB  = 0;
  localparam int INSTR_W    = 32;
  localparam int OPA_LSB    = 32;
  localparam int OPA_W      = 32;
  localparam int OPB_LSB    = 64;
  localparam int OPB_W      = 32;
  localparam int REGS_LSB   = 96;
  localparam int REGS_W     = 15;
  localparam int ALUCTL_LSB = 111;
  localparam int ALUCTL_W   = 17;

  function automatic logic [31:0] uop_instr(input logic [127:0] uop);
    return uop[INSTR_LSB +: INSTR_W];
  endfunction

endpackage

// File: rtl/id_issue_buffer_fifo.sv
// Generic circular FIFO with occupancy count and a flush that keeps a same-cycle push.
// Callers guarantee no push when full and no pop when empty.
module id_uop_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Flush moves the read pointer onto the old write pointer, so a same-cycle push survives as the only entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + AW'(i_push);
      if (i_flush) begin
        r_rdPtr <= r_wrPtr;
        r_count <= CW'(i_push);
      end else begin
        r_rdPtr <= r_rdPtr + AW'(i_pop);
        r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
    end
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/id_issue_buffer.sv
// Decode-to-EXE issue buffer with a serialisation engine for syscall and LL/SC ops:
// freeze fetch, drain, insert idle bubbles, then optionally pulse a simulator notify.
module id_issue_buffer
  import id_pkg::*;
#(
  parameter int UOP_W   = 128,
  parameter int DEPTH   = 4,
  parameter int BUBBLES = 3
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       enq_valid,
  input  logic [UOP_W-1:0]           enq_uop,
  input  logic                       enq_serial,
  input  logic                       enq_notify,
  output logic                       enq_ready,
  input  logic                       flush,
  output logic                       deq_valid,
  output logic [UOP_W-1:0]           deq_uop,
  input  logic                       deq_ready,
  output logic                       want_freeze,
  output logic                       sys_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  ser_state_e       r_state;
  ser_state_e       w_nextState;
  logic [3:0]       r_bubbleCnt;
  logic             r_notifyLatch;
  logic             r_sysOut;

  logic             w_full;
  logic             w_empty;
  logic             w_isIdle;
  logic             w_enqFire;
  logic             w_deqFire;
  logic             w_flush;
  logic [UOP_W-1:0] w_head;
  logic [CW-1:0]    w_count;

  id_uop_fifo #(
    .W     (UOP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .i_push  (w_enqFire),
    .i_pop   (w_deqFire),
    .i_flush (w_flush),
    .i_data  (enq_uop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_isIdle  = (r_state == S_IDLE);
  // Reset gates enq_ready directly so decode sees a closed buffer while reset is held.
  assign enq_ready = !RESET && w_isIdle && !w_full;
  assign w_enqFire = enq_valid && enq_ready;
  assign deq_valid = !w_empty && (r_state != S_BUBBLE);
  assign w_deqFire = deq_valid && deq_ready;
  assign w_flush   = flush && w_isIdle;

  assign deq_uop     = deq_valid ? w_head : UOP_W'(NOP_UOP);
  assign want_freeze = (r_state == S_DRAIN) || (r_state == S_BUBBLE);
  assign sys_out     = r_sysOut;
  assign count       = w_count;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (w_enqFire && enq_serial) w_nextState = S_DRAIN;
      S_DRAIN:  if (w_empty && !w_deqFire) w_nextState = S_BUBBLE;
      S_BUBBLE: if (r_bubbleCnt == 4'd1) w_nextState = S_NOTIFY;
      S_NOTIFY: w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // sys_out is registered on entry to NOTIFY so it is glitch-free for the simulator hook.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_bubbleCnt   <= '0;
      r_notifyLatch <= 1'b0;
      r_sysOut      <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_sysOut <= (w_nextState == S_NOTIFY) && r_notifyLatch;
      if (r_state == S_DRAIN && w_nextState == S_BUBBLE) begin
        r_bubbleCnt <= 4'(BUBBLES);
      end else if (r_state == S_BUBBLE) begin
        r_bubbleCnt <= r_bubbleCnt - 4'd1;
      end
      if (w_isIdle && w_enqFire && enq_serial) begin
        r_notifyLatch <= enq_notify;
      end else if (r_state == S_NOTIFY) begin
        r_notifyLatch <= 1'b0;
      end
    end
  end

endmodule

// File: doc/id_issue_buffer.md
Name: id_issue_buffer

Overview:
- Parametrised decoupling buffer between the decode stage and EXE. Holds DEPTH decoded micro-ops of UOP_W bits each.
- Generalises the fixed single-slot syscall bubble counter of the decode stage into a configurable serialisation engine. A serialising micro-op (syscall, LL/SC) freezes fetch, drains the buffer, inserts BUBBLES idle cycles, then optionally pulses a simulator notify.
- Dequeue is throttled by the data-cache stall. Branch redirects flush queued wrong-path entries.

Parameters:
- UOP_W, 128, width of one decoded micro-op bundle (instr, operands, control).
- DEPTH, 4, entry count; power of two, >=2.
- BUBBLES, 3, idle cycles inserted after a serialising op leaves the buffer; 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- enq_valid  in  1  decode offers a micro-op.
- enq_uop  in  UOP_W  micro-op payload.
- enq_serial  in  1  micro-op is serialising.
- enq_notify  in  1  with enq_serial: pulse sys_out after drain (0 for LL/SC).
- enq_ready  out  1  buffer accepts this cycle.
- flush  in  1  discard all queued entries (branch redirect).
- deq_valid  out  1  head entry valid.
- deq_uop  out  UOP_W  head payload; all-zero (NOP) when deq_valid=0.
- deq_ready  in  1  EXE consumes head (driven as !Stall_fmem).
- want_freeze  out  1  fetch must hold PC.
- sys_out  out  1  one-cycle simulator syscall notify.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset: ptrs=0, count=0, state=IDLE, bubble counter=0, notify latch=0. All outputs 0: enq_ready is 0 during reset and 1 on the first cycle after release.
- Storage is a circular array with rd_ptr/wr_ptr of log2(DEPTH) bits that wrap naturally. count is a separate register.
- Handshakes:
  - Enqueue fires on enq_valid && enq_ready.
  - Dequeue fires on deq_valid && deq_ready.
  - An entry written at edge N is visible on deq_* after edge N (1-cycle latency). There is no combinational bypass.
- enq_ready = (state==IDLE) && (count<DEPTH). When full, no enqueue is accepted even if a dequeue happens the same cycle.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- State machine:
  - IDLE
    - Normal operation; want_freeze=0.
    - A fired enqueue with enq_serial=1 stores the op, latches enq_notify, and moves to DRAIN.
  - DRAIN
    - enq_ready=0, want_freeze=1.
    - Leaves when count==0 and no dequeue is pending, i.e. the serial op has left. Then counter<=BUBBLES and the state moves to BUBBLE.
  - BUBBLE
    - want_freeze=1; deq_valid=0.
    - Counter decrements every cycle regardless of deq_ready.
    - At counter==1, moves to NOTIFY.
  - NOTIFY
    - Lasts one cycle.
    - sys_out = notify latch; want_freeze=0 (inhibit window).
    - Then returns to IDLE and clears the latch.
- sys_out is registered and high for exactly one cycle per serialising op with enq_notify=1.
- Flush:
  - In IDLE, flush empties the buffer at the edge: ptrs equalised, count=0.
  - A same-cycle enqueue is still accepted and becomes the sole entry (count=1).
  - A same-cycle dequeue is honoured (head already consumed).
  - In DRAIN, BUBBLE or NOTIFY, flush is ignored; the serialising op is architecturally committed.
- Back-to-back serialising ops: the second cannot enter until the NOTIFY cycle has passed (enq_ready=0), so no overlap is possible.
- RESET asserted mid-serialisation aborts to IDLE. sys_out drops asynchronously.
- No overflow or underflow is possible by construction. The bench asserts that count stays in 0..DEPTH.

Decomposition:
- Package id_pkg:
  - Serialisation state enum IDLE/DRAIN/BUBBLE/NOTIFY.
  - Constant NOP_UOP = 0.
  - Micro-op field offsets (instr, opA, opB, regs, ALU control).
- One sub-module: id_uop_fifo. Generic parametrised circular FIFO with flush, count, full/empty.
- The serialisation FSM stays in the top.

Test Plan:
1. Fill/drain, DEPTH=4:
   - Enqueue 0x1..0x5 with deq_ready=0 -> 4 accepted; enq_ready=0 on the 5th; count=4.
   - Raise deq_ready -> 0x1..0x4 come out in order, one per cycle.
2. Stall mid-stream:
   - deq_ready toggles 1,0,0,1 while enqueuing every cycle -> head held stable during the 0 cycles; no loss or duplication; count peaks at 3.
3. Serialising op, BUBBLES=3, enq_notify=1:
   - Enqueue A, B, then SYS -> want_freeze rises the cycle after SYS is accepted.
   - After SYS dequeues: 3 bubble cycles with deq_valid=0, then sys_out=1 for 1 cycle and want_freeze=0, then IDLE with enq_ready=1.
4. LL-type op with enq_notify=0 -> identical timing to scenario 3 but sys_out stays 0 throughout.
5. Flush:
   - With count=3, assert flush plus enqueue 0xBEEF -> next cycle count=1 and deq_uop=0xBEEF.
   - Flush during DRAIN -> ignored; the serialising op still emerges.
6. Reset during BUBBLE:
   - Assert RESET mid-countdown -> want_freeze, sys_out, count and deq_valid go 0 immediately.
   - After release, normal enqueue works.
